// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load queue.
//   - LSU_* localparams: default widths. ldq_entry_t is sized by these, so the
//     queue's XLEN / ROB_TAG_WIDTH / STQ_TAG_WIDTH / LDQ_SIZE parameters must
//     keep these values.
//   - ldq_state_e : per-entry lifecycle state.
//   - ldq_entry_t : per-entry payload.
//   - ldq_tag_in_window : tests tag membership in [base, limit) with wrap.
//   - sat_add32   : 32-bit saturating add for the optional event counters.
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam int LSU_XLEN       = 32;
    localparam int LSU_ROB_TAG_W  = 6;
    localparam int LSU_LDQ_SIZE   = 16;
    localparam int LSU_LDQ_IDX_W  = $clog2(LSU_LDQ_SIZE);
    localparam int LSU_LDQ_TAG_W  = LSU_LDQ_IDX_W + 1;
    localparam int LSU_STQ_TAG_W  = 5;

    typedef enum logic [2:0] {
        LDQ_FREE      = 3'd0,
        LDQ_WAIT_ADDR = 3'd1,
        LDQ_READY     = 3'd2,
        LDQ_ISSUED    = 3'd3,
        LDQ_SLEEP     = 3'd4,
        LDQ_EXECUTED  = 3'd5,
        LDQ_DONE      = 3'd6,
        LDQ_COMMITTED = 3'd7
    } ldq_state_e;

    typedef struct packed {
        ldq_state_e                state;
        logic [LSU_XLEN-1:0]       address;
        logic [LSU_ROB_TAG_W-1:0]  rob_tag;
        logic [LSU_STQ_TAG_W-1:0]  stq_tail;
        logic [LSU_ROB_TAG_W-1:0]  sleep_rob_tag;
        logic                      forwarded;
        logic                      order_fail;
    } ldq_entry_t;

    // True when tag lies in the half-open window [base, limit), measured as
    // distance from base so the wrap bit is handled naturally.
    function automatic logic ldq_tag_in_window(
        input logic [LSU_LDQ_TAG_W-1:0] tag,
        input logic [LSU_LDQ_TAG_W-1:0] base,
        input logic [LSU_LDQ_TAG_W-1:0] limit
    );
        logic [LSU_LDQ_TAG_W-1:0] dist_tag;
        logic [LSU_LDQ_TAG_W-1:0] dist_lim;
        dist_tag = tag - base;
        dist_lim = limit - base;
        return dist_tag < dist_lim;
    endfunction

    function automatic logic [31:0] sat_add32(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/ldq_oldest_select.sv
// ---------------------------------------------------------------------------
// ldq_oldest_select
// Rotate-by-head priority encoder: returns the first set bit of match_i
// scanning upward from head_i with wrap, i.e. the oldest matching entry.
// Ports:
//   match_i  [N]      candidate mask indexed by entry
//   head_i   [IDX_W]  index of the oldest entry
//   found_o           at least one candidate
//   index_o  [IDX_W]  entry index of the oldest candidate
//   offset_o [IDX_W]  its distance from head_i
// ---------------------------------------------------------------------------
module ldq_oldest_select #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     match_i,
    input  logic [IDX_W-1:0] head_i,
    output logic             found_o,
    output logic [IDX_W-1:0] index_o,
    output logic [IDX_W-1:0] offset_o
);

    logic [N-1:0] rotated;

    // rotated[k] is the entry k positions younger than head; N is a power of
    // two so the IDX_W-bit sum wraps exactly at the end of the queue.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [IDX_W-1:0] src;
        assign src         = head_i + IDX_W'(gi);
        assign rotated[gi] = match_i[src];
    end

    always_comb begin
        found_o  = 1'b0;
        offset_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found_o  = 1'b1;
                offset_o = IDX_W'(k);
            end
        end
    end

    assign index_o = head_i + offset_o;

endmodule

// File: rtl/load_queue_superscalar.sv
// ---------------------------------------------------------------------------
// load_queue_superscalar
// Load queue with extended head/tail pointers (MSB = wrap bit). Allocates up
// to ALLOC_WIDTH loads per cycle, issues the oldest address-ready load over a
// valid/ready handshake, and retires up to RETIRE_WIDTH committed loads per
// cycle from the head.
//
// Optional feature macro: LDQ_PERF_CNT_EN adds saturating 32-bit counters
// perf_retired_o, perf_sleeps_o, perf_forwards_o, perf_order_fails_o.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alloc_*_i / alloc_ready_o       dispatch allocation, tags in alloc_ldq_tag_o
//   agu_*_i                         address write, entry WAIT_ADDR -> READY
//   issue_*_o / issue_ready_i       oldest READY entry, handshake -> ISSUED
//   fire_result_*_i                 searcher verdict: SLEEP / EXECUTED / DONE
//   cdb_active_i, cdb_tag_i         wakes SLEEP entries waiting on the tag
//   load_succeeded_*_i              cache data returned -> DONE
//   commit_valid_i/commit_ldq_tag_i ROB commit -> COMMITTED
//   order_failures_i                sticky per-entry order-failure set
//   flush_i, flush_ldq_tail_i       drop [flush_ldq_tail_i, tail)
//   head_o, tail_o, free_count_o, ldq_order_fail_o, empty_o, full_o  status
// ---------------------------------------------------------------------------
module load_queue_superscalar
    import lsu_pkg::*;
#(
    parameter int XLEN          = LSU_XLEN,
    parameter int ROB_TAG_WIDTH = LSU_ROB_TAG_W,
    parameter int LDQ_SIZE      = LSU_LDQ_SIZE,
    parameter int LDQ_TAG_WIDTH = $clog2(LDQ_SIZE) + 1,
    parameter int STQ_TAG_WIDTH = LSU_STQ_TAG_W,
    parameter int ALLOC_WIDTH   = 2,
    parameter int RETIRE_WIDTH  = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [ALLOC_WIDTH-1:0]                 alloc_valid_i,
    input  logic [ALLOC_WIDTH*ROB_TAG_WIDTH-1:0]   alloc_rob_tag_i,
    input  logic [ALLOC_WIDTH*STQ_TAG_WIDTH-1:0]   alloc_stq_tail_i,
    output logic                                   alloc_ready_o,
    output logic [ALLOC_WIDTH*LDQ_TAG_WIDTH-1:0]   alloc_ldq_tag_o,
    input  logic                                   agu_valid_i,
    input  logic [LDQ_TAG_WIDTH-1:0]               agu_ldq_tag_i,
    input  logic [XLEN-1:0]                        agu_address_i,
    output logic                                   issue_valid_o,
    output logic [LDQ_TAG_WIDTH-1:0]               issue_ldq_tag_o,
    output logic [XLEN-1:0]                        issue_address_o,
    input  logic                                   issue_ready_i,
    input  logic                                   fire_result_valid_i,
    input  logic [LDQ_TAG_WIDTH-1:0]               fire_result_tag_i,
    input  logic                                   fire_result_sleep_i,
    input  logic [ROB_TAG_WIDTH-1:0]               fire_result_sleep_rob_tag_i,
    input  logic                                   fire_result_forward_i,
    input  logic                                   cdb_active_i,
    input  logic [ROB_TAG_WIDTH-1:0]               cdb_tag_i,
    input  logic                                   load_succeeded_i,
    input  logic [LDQ_TAG_WIDTH-1:0]               load_succeeded_tag_i,
    input  logic [RETIRE_WIDTH-1:0]                commit_valid_i,
    input  logic [RETIRE_WIDTH*LDQ_TAG_WIDTH-1:0]  commit_ldq_tag_i,
    input  logic [LDQ_SIZE-1:0]                    order_failures_i,
    input  logic                                   flush_i,
    input  logic [LDQ_TAG_WIDTH-1:0]               flush_ldq_tail_i,
    output logic [LDQ_TAG_WIDTH-1:0]               head_o,
    output logic [LDQ_TAG_WIDTH-1:0]               tail_o,
    output logic [LDQ_TAG_WIDTH-1:0]               free_count_o,
    output logic [LDQ_SIZE-1:0]                    ldq_order_fail_o,
    output logic                                   empty_o,
    output logic                                   full_o
`ifdef LDQ_PERF_CNT_EN
    ,
    output logic [31:0]                            perf_retired_o,
    output logic [31:0]                            perf_sleeps_o,
    output logic [31:0]                            perf_forwards_o,
    output logic [31:0]                            perf_order_fails_o
`endif
);

    localparam int IDX_W = LDQ_TAG_WIDTH - 1;

    ldq_entry_t entries_q [LDQ_SIZE];
    ldq_entry_t entries_d [LDQ_SIZE];

    logic [LDQ_TAG_WIDTH-1:0] head_q, head_d;
    logic [LDQ_TAG_WIDTH-1:0] tail_q, tail_d;
    logic [LDQ_TAG_WIDTH-1:0] occupancy;
    logic [LDQ_TAG_WIDTH-1:0] alloc_count;
    logic [LDQ_TAG_WIDTH-1:0] retire_cnt;
    logic                     alloc_fire;

    logic [LDQ_SIZE-1:0] ready_mask;
    logic [LDQ_SIZE-1:0] retire_mask;
    logic [LDQ_SIZE-1:0] flush_mask;

    logic             sel_found;
    logic [IDX_W-1:0] sel_index;
    logic [IDX_W-1:0] sel_offset;
    logic             issue_fire;

    logic [IDX_W-1:0] agu_idx;
    logic [IDX_W-1:0] fire_idx;
    logic [IDX_W-1:0] succ_idx;
    logic             fire_ok;
    logic             fire_wake_now;

    // ------------------------------------------------------------------
    // Pointer status
    // ------------------------------------------------------------------
    assign occupancy     = tail_q - head_q;
    assign free_count_o  = LDQ_TAG_WIDTH'(LDQ_SIZE) - occupancy;
    assign alloc_ready_o = free_count_o >= LDQ_TAG_WIDTH'(ALLOC_WIDTH);
    assign alloc_fire    = alloc_ready_o && !flush_i;
    assign head_o        = head_q;
    assign tail_o        = tail_q;
    assign empty_o       = (tail_q == head_q);
    assign full_o        = (tail_q[IDX_W-1:0] == head_q[IDX_W-1:0]) &&
                           (tail_q[IDX_W] != head_q[IDX_W]);

    for (genvar gi = 0; gi < ALLOC_WIDTH; gi++) begin : g_alloc_tag
        assign alloc_ldq_tag_o[gi*LDQ_TAG_WIDTH +: LDQ_TAG_WIDTH] =
            tail_q + LDQ_TAG_WIDTH'(gi);
    end

    always_comb begin
        alloc_count = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            alloc_count = alloc_count + LDQ_TAG_WIDTH'(alloc_valid_i[k]);
        end
    end

    // ------------------------------------------------------------------
    // Per-entry masks: issue candidates, order flags, flush window
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < LDQ_SIZE; gi++) begin : g_entry
        logic [IDX_W-1:0]         off;
        logic [LDQ_TAG_WIDTH-1:0] etag;
        assign ready_mask[gi]       = (entries_q[gi].state == LDQ_READY);
        assign ldq_order_fail_o[gi] = entries_q[gi].order_fail;
        // Reconstruct the full tag (with wrap bit) of this slot from head.
        assign off            = IDX_W'(gi) - head_q[IDX_W-1:0];
        assign etag           = head_q + {1'b0, off};
        assign flush_mask[gi] = flush_i &&
                                ldq_tag_in_window(etag, flush_ldq_tail_i, tail_q);
    end

    // ------------------------------------------------------------------
    // Issue select
    // ------------------------------------------------------------------
    ldq_oldest_select #(
        .N     (LDQ_SIZE),
        .IDX_W (IDX_W)
    ) u_select (
        .match_i  (ready_mask),
        .head_i   (head_q[IDX_W-1:0]),
        .found_o  (sel_found),
        .index_o  (sel_index),
        .offset_o (sel_offset)
    );

    assign issue_valid_o   = sel_found;
    assign issue_ldq_tag_o = head_q + {1'b0, sel_offset};
    assign issue_address_o = entries_q[sel_index].address;
    assign issue_fire      = sel_found && issue_ready_i;

    // ------------------------------------------------------------------
    // Retire: contiguous COMMITTED run from head, looked up in the
    // registered state so a commit retires one cycle later at the earliest.
    // ------------------------------------------------------------------
    always_comb begin
        logic             run_open;
        logic [IDX_W-1:0] ridx;
        retire_cnt  = '0;
        retire_mask = '0;
        run_open    = 1'b1;
        ridx        = '0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            ridx = head_q[IDX_W-1:0] + IDX_W'(k);
            if (run_open && (LDQ_TAG_WIDTH'(k) < occupancy) &&
                (entries_q[ridx].state == LDQ_COMMITTED)) begin
                retire_mask[ridx] = 1'b1;
                retire_cnt        = retire_cnt + 1'b1;
            end else begin
                run_open = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry next-state. Event conditions look at entries_q; later writes
    // override earlier ones, and flush is applied last so it wins.
    // ------------------------------------------------------------------
    assign agu_idx       = agu_ldq_tag_i[IDX_W-1:0];
    assign fire_idx      = fire_result_tag_i[IDX_W-1:0];
    assign succ_idx      = load_succeeded_tag_i[IDX_W-1:0];
    assign fire_ok       = fire_result_valid_i &&
                           (entries_q[fire_idx].state == LDQ_ISSUED);
    assign fire_wake_now = cdb_active_i && (cdb_tag_i == fire_result_sleep_rob_tag_i);

    always_comb begin
        logic [IDX_W-1:0] cidx;
        logic [IDX_W-1:0] aidx;
        cidx = '0;
        aidx = '0;
        for (int i = 0; i < LDQ_SIZE; i++) begin
            entries_d[i] = entries_q[i];
        end

        if (agu_valid_i && (entries_q[agu_idx].state == LDQ_WAIT_ADDR)) begin
            entries_d[agu_idx].address = agu_address_i;
            entries_d[agu_idx].state   = LDQ_READY;
        end

        if (issue_fire) begin
            entries_d[sel_index].state = LDQ_ISSUED;
        end

        // A sleep verdict means the store data is missing, so it outranks
        // a forward indication on the same verdict.
        if (fire_ok) begin
            if (fire_result_sleep_i) begin
                entries_d[fire_idx].sleep_rob_tag = fire_result_sleep_rob_tag_i;
                entries_d[fire_idx].state = fire_wake_now ? LDQ_READY : LDQ_SLEEP;
            end else if (fire_result_forward_i) begin
                entries_d[fire_idx].forwarded = 1'b1;
                entries_d[fire_idx].state     = LDQ_DONE;
            end else begin
                entries_d[fire_idx].state = LDQ_EXECUTED;
            end
        end

        for (int i = 0; i < LDQ_SIZE; i++) begin
            if (cdb_active_i && (entries_q[i].state == LDQ_SLEEP) &&
                (cdb_tag_i == entries_q[i].sleep_rob_tag)) begin
                entries_d[i].state = LDQ_READY;
            end
        end

        if (load_succeeded_i && ((entries_q[succ_idx].state == LDQ_EXECUTED) ||
                                 (entries_q[succ_idx].state == LDQ_ISSUED))) begin
            entries_d[succ_idx].state = LDQ_DONE;
        end

        // The ROB commits in order and only completed loads; it is the
        // authority here, so any live entry may be marked committed.
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            cidx = commit_ldq_tag_i[k*LDQ_TAG_WIDTH +: IDX_W];
            if (commit_valid_i[k] && (entries_q[cidx].state != LDQ_FREE)) begin
                entries_d[cidx].state = LDQ_COMMITTED;
            end
        end

        for (int i = 0; i < LDQ_SIZE; i++) begin
            if (order_failures_i[i] && (entries_q[i].state != LDQ_FREE)) begin
                entries_d[i].order_fail = 1'b1;
            end
        end

        if (alloc_fire) begin
            for (int k = 0; k < ALLOC_WIDTH; k++) begin
                aidx = tail_q[IDX_W-1:0] + IDX_W'(k);
                if (alloc_valid_i[k]) begin
                    entries_d[aidx]          = '0;
                    entries_d[aidx].state    = LDQ_WAIT_ADDR;
                    entries_d[aidx].rob_tag  = alloc_rob_tag_i[k*ROB_TAG_WIDTH +: ROB_TAG_WIDTH];
                    entries_d[aidx].stq_tail = alloc_stq_tail_i[k*STQ_TAG_WIDTH +: STQ_TAG_WIDTH];
                end
            end
        end

        for (int i = 0; i < LDQ_SIZE; i++) begin
            if (retire_mask[i] || flush_mask[i]) begin
                entries_d[i] = '0;
            end
        end
    end

    assign head_d = head_q + retire_cnt;
    assign tail_d = flush_i    ? flush_ldq_tail_i :
                    alloc_fire ? tail_q + alloc_count : tail_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < LDQ_SIZE; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < LDQ_SIZE; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    // Payload the downstream searcher consumes, plus tag wrap bits that
    // only the index is needed from; gathered so they are visibly accounted.
    logic unused_bits;
    always_comb begin
        unused_bits = agu_ldq_tag_i[IDX_W] ^ fire_result_tag_i[IDX_W] ^
                      load_succeeded_tag_i[IDX_W];
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            unused_bits = unused_bits ^ commit_ldq_tag_i[k*LDQ_TAG_WIDTH + IDX_W];
        end
        for (int i = 0; i < LDQ_SIZE; i++) begin
            unused_bits = unused_bits ^ (^entries_q[i].rob_tag) ^
                          (^entries_q[i].stq_tail) ^ entries_q[i].forwarded;
        end
    end

`ifdef LDQ_PERF_CNT_EN
    logic [31:0] perf_retired_q, perf_sleeps_q, perf_forwards_q, perf_order_fails_q;
    logic [31:0] new_order_fails;

    // Count only flags that actually transition from clear to set.
    always_comb begin
        new_order_fails = '0;
        for (int i = 0; i < LDQ_SIZE; i++) begin
            if (order_failures_i[i] && (entries_q[i].state != LDQ_FREE) &&
                !entries_q[i].order_fail) begin
                new_order_fails = new_order_fails + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired_q     <= '0;
            perf_sleeps_q      <= '0;
            perf_forwards_q    <= '0;
            perf_order_fails_q <= '0;
        end else begin
            perf_retired_q     <= sat_add32(perf_retired_q, 32'(retire_cnt));
            perf_sleeps_q      <= sat_add32(perf_sleeps_q,
                                            32'(fire_ok && fire_result_sleep_i));
            perf_forwards_q    <= sat_add32(perf_forwards_q,
                                            32'(fire_ok && !fire_result_sleep_i &&
                                                fire_result_forward_i));
            perf_order_fails_q <= sat_add32(perf_order_fails_q, new_order_fails);
        end
    end

    assign perf_retired_o     = perf_retired_q;
    assign perf_sleeps_o      = perf_sleeps_q;
    assign perf_forwards_o    = perf_forwards_q;
    assign perf_order_fails_o = perf_order_fails_q;
`endif

endmodule

// File: doc/load_queue_superscalar.md
Name: load_queue_superscalar

Overview:
Next-generation load queue for the out-of-order LSU. It tracks in-flight loads with extended head and tail pointers instead of a valid-array scan, and accepts up to ALLOC_WIDTH loads per cycle. It selects the oldest address-ready load for firing through a valid/ready handshake and retires up to RETIRE_WIDTH committed loads per cycle. It sits between dispatch/ROB, the AGUs, the load/store searcher and the data-cache port.

Parameters:
XLEN, 32, data/address width
ROB_TAG_WIDTH, 6, ROB tag width
LDQ_SIZE, 16, entries; power of two, >=4
LDQ_TAG_WIDTH, $clog2(LDQ_SIZE)+1, extended tag (MSB = wrap bit)
STQ_TAG_WIDTH, 5, extended store-queue tag
ALLOC_WIDTH, 2, loads allocated per cycle (1..4)
RETIRE_WIDTH, 2, entries freed per cycle (1..4)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
alloc_valid  in  ALLOC_WIDTH  per-slot alloc request; set bits contiguous from bit 0
alloc_rob_tag  in  ALLOC_WIDTH*ROB_TAG_WIDTH  ROB tag per slot
alloc_stq_tail  in  ALLOC_WIDTH*STQ_TAG_WIDTH  STQ tail snapshot (store dependence)
alloc_ready  out  1  free_count >= ALLOC_WIDTH
alloc_ldq_tag  out  ALLOC_WIDTH*LDQ_TAG_WIDTH  tag assigned to slot k = tail+k
agu_valid  in  1  AGU address valid
agu_ldq_tag  in  LDQ_TAG_WIDTH  target entry
agu_address  in  XLEN  address
issue_valid  out  1  an oldest READY entry exists
issue_ldq_tag  out  LDQ_TAG_WIDTH  selected entry
issue_address  out  XLEN  its address
issue_ready  in  1  cache/searcher accepts the issue
fire_result_valid  in  1  searcher verdict for an issued load
fire_result_tag  in  LDQ_TAG_WIDTH  entry
fire_result_sleep  in  1  store data not yet available
fire_result_sleep_rob_tag  in  ROB_TAG_WIDTH  store to wait on
fire_result_forward  in  1  data forwarded from STQ
cdb_active  in  1  CDB broadcast
cdb_tag  in  ROB_TAG_WIDTH  broadcast tag
load_succeeded  in  1  cache returned data
load_succeeded_tag  in  LDQ_TAG_WIDTH  entry
commit_valid  in  RETIRE_WIDTH  ROB commits loads (in order)
commit_ldq_tag  in  RETIRE_WIDTH*LDQ_TAG_WIDTH  committed entries
order_failures  in  LDQ_SIZE  set order_fail per entry
flush  in  1  pipeline flush
flush_ldq_tail  in  LDQ_TAG_WIDTH  new tail; entries in [flush_ldq_tail, tail) freed
head, tail  out  LDQ_TAG_WIDTH each  pointers
free_count  out  $clog2(LDQ_SIZE)+1  LDQ_SIZE - (tail-head)
ldq_order_fail  out  LDQ_SIZE  per-entry order-failure flags
empty, full  out  1 each  tail==head / index equal and wrap differs

Behaviour:
- Reset (async, reset==0): head=tail=0, all entries FREE, all flags/addresses 0, issue_valid=0, free_count=LDQ_SIZE, empty=1.
- Per-entry state (3-bit enum): FREE -> WAIT_ADDR (alloc) -> READY (agu write) -> ISSUED (issue handshake) -> SLEEP | EXECUTED (fire_result) -> DONE (load_succeeded, or immediately with forward) -> COMMITTED (commit) -> FREE (retire).
- SLEEP -> READY when cdb_active && cdb_tag == sleep_rob_tag. A CDB match in the same cycle as the sleep verdict wakes the entry straight to READY.
- Alloc: when alloc_ready, slot k writes entry tail+k. Tail advances by popcount(alloc_valid). Alloc is ignored entirely when alloc_ready=0 or flush=1.
- Issue: combinational select of the oldest READY entry, searched from head with wrap. The entry transitions to ISSUED only on issue_valid&&issue_ready; if issue_ready=0, the entry stays READY.
- Retire: each cycle, free the longest run (<=RETIRE_WIDTH) of COMMITTED entries starting at head; head advances by that run length. An entry committed in cycle N retires in N+1 at the earliest.
- Flush: tail <= flush_ldq_tail; entries in [flush_ldq_tail, old tail) go FREE. Flush has priority over alloc, agu, fire_result, wakeup and succeed for those entries. Retire and older entries are unaffected.
- Pointer arithmetic: modulo 2^LDQ_TAG_WIDTH. Index = low $clog2(LDQ_SIZE) bits.
- Updates addressed to a FREE entry are ignored. order_fail is sticky until the entry is freed.

Optional Feature:
LDQ_PERF_CNT_EN:
- Defined: adds 32-bit saturating output counters perf_retired, perf_sleeps, perf_forwards, perf_order_fails, all reset to 0.
- Undefined: counters and their ports are absent.

Decomposition:
- Package lsu_pkg: ldq_state_e enum, ldq_entry_t struct (state, address, rob_tag, stq_tail, sleep_rob_tag, forwarded, order_fail), and a tag-age compare function.
- Sub-module ldq_oldest_select: rotate-by-head priority encoder returning the oldest matching index plus a found flag.

Test Plan:
- Two allocs/cycle for 8 cycles, LDQ_SIZE=16 -> tail=16 (wrap bit set), full=1, alloc_ready=0, free_count=0.
- Entries 3 and 1 get addresses in the same cycle -> issue_ldq_tag=1 first. With issue_ready held 0 for 3 cycles, the tag stays 1.
- Fire entry 2 with sleep, rob_tag=9; cdb_tag=9 two cycles later -> entry 2 returns to READY and re-issues.
- Entries 0-2 COMMITTED, RETIRE_WIDTH=2 -> head=2 next cycle, head=3 the following cycle.
- tail=10, flush with flush_ldq_tail=6 -> entries 6-9 FREE, tail=6; a same-cycle alloc is ignored.
- Assert reset mid-operation with entries in ISSUED -> immediately all FREE, issue_valid=0, head=tail=0.
